fifo_rd_stream: RTL and testbench

Read-domain controller for the async FIFO. It runs entirely on rclk and performs these tasks:
- synchronises the Gray write pointer from the write domain;
- maintains the binary and Gray read pointers;
- generates the registered empty flag;
- drives the binary read address into the FIFO memory, which has a combinational read port.

It presents popped words on a registered valid/ready stream output with one-word prefetch. It is the reader counterpart to the write-side pointer/full logic.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/fifo_rd_stream.sv | 76 +++++++
 tb/tb_fifo_rd_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer conversion.
package fifo_pkg;

    localparam int unsigned PTR_WIDTH_DEF  = 3;
    localparam int unsigned DEPTH_DEF      = 8;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    // Conversion functions work on a wide container; callers cast to pointer width.
    localparam int unsigned PTR_MAX_W = 16;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for multi-bit Gray-coded pointers crossing clock domains.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Async FIFO read-domain controller: pointer sync, read pointers, empty/level flags
// and a one-word prefetch register presented as a valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PTR_WIDTH  = PTR_WIDTH_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [PTR_WIDTH:0]    g_wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  r_en,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    rd_level,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam int unsigned PW = PTR_WIDTH + 1;

    if (DEPTH != (32'd1 << PTR_WIDTH)) begin : g_depth_check
        $error("fifo_rd_stream: DEPTH must equal 2**PTR_WIDTH");
    end

    logic [PW-1:0] wq2;
    logic [PW-1:0] wbin;
    logic [PW-1:0] b_rptr_next;
    logic [PW-1:0] g_rptr_next;
    logic          pop;

    sync_2ff #(.WIDTH(PW)) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (g_wptr),
        .q     (wq2)
    );

    // Pop whenever memory has a word and the output register is free or draining.
    always_comb begin
        pop         = !empty && (!m_valid || m_ready);
        b_rptr_next = b_rptr + PW'(pop);
        g_rptr_next = PW'(bin2gray(PTR_MAX_W'(b_rptr_next)));
        wbin        = PW'(gray2bin(PTR_MAX_W'(wq2)));
    end

    assign r_en = pop;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr   <= '0;
            g_rptr   <= '0;
            empty    <= 1'b1;
            rd_level <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            b_rptr   <= b_rptr_next;
            g_rptr   <= g_rptr_next;
            // Looking ahead at the next pointer raises empty on the edge of the last pop.
            empty    <= (g_rptr_next == wq2);
            rd_level <= wbin - b_rptr_next;
            if (pop) begin
                m_data  <= mem_rdata;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural write side and scoreboard.
module tb_fifo_rd_stream;

    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = 4;
    localparam int unsigned DEPTH = 8;

    logic          rclk;
    logic          rrst_n;
    logic [PW-1:0] g_wptr;
    logic [DW-1:0] mem_rdata;
    logic [PW-1:0] b_rptr;
    logic [PW-1:0] g_rptr;
    logic          r_en;
    logic          empty;
    logic [PW-1:0] rd_level;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] wptr;
    int checks = 0;
    int errors = 0;

    fifo_rd_stream #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_WIDTH(PW-1)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .g_wptr    (g_wptr),
        .mem_rdata (mem_rdata),
        .b_rptr    (b_rptr),
        .g_rptr    (g_rptr),
        .r_en      (r_en),
        .empty     (empty),
        .rd_level  (rd_level),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
    );

    assign mem_rdata = mem[b_rptr[2:0]];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic apply_reset();
        rrst_n  = 1'b0;
        m_ready = 1'b0;
        g_wptr  = '0;
        wptr    = '0;
        exp_q.delete();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        rrst_n  = 1'b0;
        g_wptr  = 4'b0110;
        m_ready = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (b_rptr !== 4'd0) begin errors++; $display("FAIL reset_b_rptr: got %0d expected 0", b_rptr); end
        checks++; if (g_rptr !== 4'd0) begin errors++; $display("FAIL reset_g_rptr: got %b expected 0000", g_rptr); end
        checks++; if (rd_level !== 4'd0) begin errors++; $display("FAIL reset_rd_level: got %0d expected 0", rd_level); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b expected 0", r_en); end
        rrst_n = 1'b1;
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL release_empty_e1: got %b expected 1", empty); end
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL release_empty_e2: got %b expected 1", empty); end
        step();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL release_empty_e3: got %b expected 0", empty); end
        checks++; if (rd_level !== 4'd4) begin errors++; $display("FAIL release_level_e3: got %0d expected 4", rd_level); end
    endtask

    task automatic test_single();
        apply_reset();
        mem[0]  = 8'hA5;
        g_wptr  = 4'b0001;
        m_ready = 1'b1;
        step();
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_e2: got %b expected 1", empty); end
        step();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_e3: got %b expected 0", empty); end
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL single_r_en_e3: got %b expected 1", r_en); end
        checks++; if (rd_level !== 4'd1) begin errors++; $display("FAIL single_level_e3: got %0d expected 1", rd_level); end
        step();
        checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", m_data); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e4: got %b expected 1", m_valid); end
        checks++; if (b_rptr !== 4'd1) begin errors++; $display("FAIL single_b_rptr: got %0d expected 1", b_rptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_e4: got %b expected 1", empty); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL single_r_en_e4: got %b expected 0", r_en); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e5: got %b expected 0", m_valid); end
        checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h expected a5", m_data); end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] words [3];
        words = '{8'h11, 8'h22, 8'h33};
        apply_reset();
        for (int i = 0; i < 3; i++) mem[i] = words[i];
        g_wptr = 4'b0010;
        repeat (3) step();
        checks++; if (rd_level !== 4'd3) begin errors++; $display("FAIL bp_level_e3: got %0d expected 3", rd_level); end
        step();
        for (int c = 0; c < 3; c++) begin
            checks++; if (m_data !== 8'h11 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b expected 11/1", m_data, m_valid); end
            checks++; if (b_rptr !== 4'd1 || rd_level !== 4'd2) begin errors++; $display("FAIL bp_ptr_level: got %0d/%0d expected 1/2", b_rptr, rd_level); end
            checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL bp_no_pop: got %b expected 0", r_en); end
            if (c < 2) step();
        end
        m_ready = 1'b1;
        #1;
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL bp_refill_pop: got %b expected 1", r_en); end
        for (int i = 1; i < 3; i++) begin
            step();
            checks++; if (m_data !== words[i] || m_valid !== 1'b1) begin errors++; $display("FAIL bp_drain: got %h/%b expected %h/1", m_data, m_valid, words[i]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b expected 1", empty); end
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", m_valid); end
    endtask

    task automatic test_full_level();
        logic [DW-1:0] words [DEPTH];
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = DW'($urandom);
            mem[i]   = words[i];
        end
        g_wptr = 4'b1100;
        repeat (3) step();
        checks++; if (rd_level !== 4'd8) begin errors++; $display("FAIL full_level_pre: got %0d expected 8", rd_level); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty_pre: got %b expected 0", empty); end
        step();
        checks++; if (rd_level !== 4'd7) begin errors++; $display("FAIL full_level_post: got %0d expected 7", rd_level); end
        checks++; if (m_data !== words[0] || m_valid !== 1'b1) begin errors++; $display("FAIL full_first: got %h/%b expected %h/1", m_data, m_valid, words[0]); end
        m_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            step();
            checks++; if (m_data !== words[i] || m_valid !== 1'b1) begin errors++; $display("FAIL full_drain[%0d]: got %h/%b expected %h/1", i, m_data, m_valid, words[i]); end
        end
        checks++; if (empty !== 1'b1 || b_rptr !== 4'd8) begin errors++; $display("FAIL full_end: got empty=%b b_rptr=%0d expected 1/8", empty, b_rptr); end
        step();
        checks++; if (m_valid !== 1'b0 || rd_level !== 4'd0) begin errors++; $display("FAIL full_idle: got valid=%b level=%0d expected 0/0", m_valid, rd_level); end
    endtask

    // Random write bursts and back-pressure against an in-order scoreboard.
    task automatic run_stream(input int n, input int rdy_pct, input int wr_pct,
                              output bit saw_msb, output bit saw_wrap);
        int written, received, pops, cyc;
        bit pv, pr, pe;
        logic [DW-1:0] pd, d, exp_d;
        logic [PW-1:0] prev_b, prev_g, dx;
        apply_reset();
        written = 0; received = 0; pops = 0; cyc = 0;
        saw_msb = 1'b0; saw_wrap = 1'b0;
        prev_b = b_rptr; prev_g = g_rptr;
        while (received < n && cyc < 20000) begin
            if (written < n && $urandom_range(99) < wr_pct && PW'(wptr - b_rptr) < PW'(DEPTH)) begin
                d = DW'($urandom);
                mem[wptr[2:0]] = d;
                exp_q.push_back(d);
                wptr    = wptr + 4'd1;
                g_wptr  = wptr ^ (wptr >> 1);
                written++;
            end
            m_ready = ($urandom_range(99) < rdy_pct);
            #1;
            pv = m_valid; pr = m_ready; pd = m_data; pe = r_en;
            if (pe) pops++;
            checks++; if (pops > written) begin errors++; $display("FAIL stream_underflow: got %0d pops expected at most %0d", pops, written); end
            step();
            cyc++;
            if (pv && pr) begin
                received++;
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++; if (pd !== exp_d) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", received - 1, pd, exp_d); end
            end else if (pv) begin
                checks++; if (m_valid !== 1'b1 || m_data !== pd) begin errors++; $display("FAIL stream_stall: got %h/%b expected %h/1", m_data, m_valid, pd); end
            end
            dx = g_rptr ^ prev_g;
            checks++; if ((dx & (dx - 4'd1)) !== 4'd0 || g_rptr !== (b_rptr ^ (b_rptr >> 1))) begin
                errors++; $display("FAIL stream_gray: got %b (prev %b, b_rptr %0d) expected one-bit Gray step", g_rptr, prev_g, b_rptr);
            end
            if (prev_b == 4'd7 && b_rptr == 4'd8) saw_msb = 1'b1;
            if (prev_b == 4'd15 && b_rptr == 4'd0) saw_wrap = 1'b1;
            prev_b = b_rptr; prev_g = g_rptr;
        end
        checks++; if (received != n) begin errors++; $display("FAIL stream_timeout: got %0d words expected %0d", received, n); end
        m_ready = 1'b0;
        repeat (3) step();
        checks++; if (empty !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL stream_end_flags: got empty=%b valid=%b expected 1/0", empty, m_valid); end
        checks++; if (b_rptr !== PW'(n) || rd_level !== 4'd0) begin errors++; $display("FAIL stream_end_ptr: got b_rptr=%0d level=%0d expected %0d/0", b_rptr, rd_level, PW'(n)); end
        checks++; if (pops != n) begin errors++; $display("FAIL stream_pops: got %0d expected %0d", pops, n); end
    endtask

    task automatic test_wrap();
        bit saw_msb, saw_wrap;
        run_stream(20, 70, 80, saw_msb, saw_wrap);
        checks++; if (!saw_msb) begin errors++; $display("FAIL wrap_msb: got 0 expected b_rptr 7->8"); end
        checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_zero: got 0 expected b_rptr 15->0"); end
        checks++; if (b_rptr !== 4'd4) begin errors++; $display("FAIL wrap_final: got %0d expected 4", b_rptr); end
    endtask

    task automatic test_random();
        bit saw_msb, saw_wrap;
        run_stream(300, 60, 50, saw_msb, saw_wrap);
        run_stream(200, 30, 90, saw_msb, saw_wrap);
        run_stream(200, 100, 100, saw_msb, saw_wrap);
    endtask

    task automatic test_mid_reset();
        int cyc;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        wptr    = 4'd8;
        g_wptr  = 4'b1100;
        m_ready = 1'b1;
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL midrst_start: got %b expected 1", m_valid); end
        #3;
        rrst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("FAIL midrst_output: got %h/%b expected 00/0", m_data, m_valid); end
        checks++; if (b_rptr !== 4'd0 || g_rptr !== 4'd0) begin errors++; $display("FAIL midrst_ptrs: got %0d/%b expected 0/0000", b_rptr, g_rptr); end
        checks++; if (empty !== 1'b1 || rd_level !== 4'd0) begin errors++; $display("FAIL midrst_flags: got empty=%b level=%0d expected 1/0", empty, rd_level); end
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL midrst_r_en: got %b expected 0", r_en); end
        end
        step();
        rrst_n = 1'b1;
        repeat (3) step();
        checks++; if (empty !== 1'b0 || rd_level !== 4'd8) begin errors++; $display("FAIL midrst_recover: got empty=%b level=%0d expected 0/8", empty, rd_level); end
    endtask

    initial begin
        rrst_n  = 1'b0;
        g_wptr  = '0;
        m_ready = 1'b0;
        wptr    = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_single();
        test_back_pressure();
        test_full_level();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
